// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Brief    : I2S receiver; oversamples sclk/lrclk/sdi in the clk domain and
//            delivers DW-bit words with channel tag over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int DW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdi,
    output logic [DW-1:0] o_sample,
    output logic          o_channel,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_overflow
);

    localparam int              c_cnt_w = $clog2(DW + 1);
    localparam logic [c_cnt_w-1:0] c_dw   = c_cnt_w'(DW);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DW - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sclk_prev;
    logic                   r_lr_prev;
    logic                   r_primed;
    logic                   r_init;
    logic                   r_chan;
    logic [c_cnt_w-1:0]     r_cnt;
    // The final bit of each word goes straight into o_sample, so only
    // DW-1 bits need to be held here.
    logic [DW-2:0]          r_shift;

    logic          w_sclk;
    logic          w_lr;
    logic          w_sdi;
    logic          w_strobe;
    logic          w_slot_start;
    logic          w_capture;
    logic          w_load;
    logic [DW-1:0] w_shift_next;

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_lr         = r_lr_sync[SYNC_STAGES-1];
    assign w_sdi        = r_sdi_sync[SYNC_STAGES-1];
    assign w_strobe     = w_sclk & ~r_sclk_prev;
    assign w_slot_start = w_strobe & r_primed & (w_lr != r_lr_prev);
    assign w_capture    = w_strobe & r_primed & r_init & (w_lr == r_lr_prev) & (r_cnt < c_dw);
    assign w_load       = w_capture & (r_cnt == c_last);
    assign w_shift_next = {r_shift, w_sdi};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sdi_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_lr_prev   <= 1'b0;
            r_primed    <= 1'b0;
            r_init      <= 1'b0;
            r_chan      <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            o_sample    <= '0;
            o_channel   <= 1'b0;
            o_valid     <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], lrclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sclk_prev <= w_sclk;

            // The first strobe after reset only records lrclk, so that a
            // reset landing mid-slot is never mistaken for a slot boundary.
            if (w_strobe) begin
                r_lr_prev <= w_lr;
                r_primed  <= 1'b1;
                if (w_slot_start) begin
                    r_init <= 1'b1;
                    r_cnt  <= '0;
                    r_chan <= w_lr;
                end else if (w_capture) begin
                    r_shift <= w_shift_next[DW-2:0];
                    r_cnt   <= r_cnt + c_one;
                end
            end

            if (w_load) begin
                o_sample   <= w_shift_next;
                o_channel  <= r_chan;
                o_valid    <= 1'b1;
                o_overflow <= o_valid & ~i_ready;
            end else begin
                o_overflow <= 1'b0;
                if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DW, default 24, sets the sample width in bits and the number of data bits captured per channel slot.
REQ-002 Parameter SYNC_STAGES, default 2, sets the flip-flop depth of each input synchronizer; minimum 2.
REQ-003 clk  input  1  system clock; one clock only; sclk high and low phases each last at least 2 clk periods.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 sclk  input  1  I2S bit clock from an external master; asynchronous to clk.
REQ-006 lrclk  input  1  I2S word select; 0 = left, 1 = right; asynchronous to clk.
REQ-007 sdi  input  1  I2S serial data, MSB first; asynchronous to clk.
REQ-008 o_sample  output  DW  received sample, two's complement, as transmitted.
REQ-009 o_channel  output  1  channel of o_sample; 0 = left, 1 = right.
REQ-010 o_valid  output  1  o_sample and o_channel hold an unconsumed word.
REQ-011 i_ready  input  1  downstream accepts the word; a transfer occurs on any clk edge with o_valid && i_ready.
REQ-012 o_overflow  output  1  one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-013 sclk, lrclk and sdi each pass through a SYNC_STAGES synchronizer; all logic uses only the synchronized copies.
REQ-014 The block generates an internal one-cycle strobe on each synchronized sclk rising edge; falling edges are ignored.
REQ-015 All bit-level state changes occur only on strobe cycles, when synchronized lrclk and sdi are sampled together.
REQ-016 State lr_prev holds lrclk as sampled at the previous strobe; on a strobe where sampled lrclk != lr_prev, a new slot begins.
REQ-017 At slot start: bit counter = 0; slot channel = sampled lrclk; sdi is not captured, because that bit is the I2S one-bit delay.
REQ-018 On each later strobe in the slot, while bit counter < DW: shift sdi into the LSB of a DW-bit shift register and increment the counter.
REQ-019 When the counter reaches DW, the full word plus slot channel load into o_sample/o_channel, and o_valid is high on the next cycle.
REQ-020 Latency: o_valid is high after the 3rd clk edge counting from the edge that first samples the DW-th data sclk rise high (SYNC_STAGES=2).
REQ-021 Bits beyond DW in a slot (slot longer than DW) are ignored; the counter saturates at DW until the next slot start.
REQ-022 If lrclk toggles before DW bits are captured, the partial word is discarded silently and no o_valid is raised.
REQ-023 o_valid, o_sample and o_channel stay stable until a transfer; o_valid drops on the cycle after the transfer unless a new word loads on that same edge.
REQ-024 New word completes while o_valid && !i_ready: output is overwritten with the new word, o_valid stays 1, o_overflow pulses for 1 cycle.
REQ-025 New word completes on the same edge as a transfer: the new word loads, o_valid stays 1, and no overflow occurs.
REQ-026 After reset, no word is captured until the first lrclk transition is observed, which requires an initialization flag; the first slot is therefore always complete.

Reset
REQ-027 rst high at a clk edge: o_valid=0, o_overflow=0, o_sample=0, o_channel=0, bit counter=0, shift register=0, init flag cleared, synchronizers and lr_prev=0.
REQ-028 Reset mid-slot discards the partial word; capture resumes only after the next observed lrclk transition.

Verification
REQ-029 clk=12.288MHz, sclk=clk/8, standard I2S frames, left=0x123456, right=0xABCDEF, i_ready=1 -> alternating words 0x123456/ch0 and 0xABCDEF/ch1, one o_valid pulse each, no overflow.
REQ-030 32-bit slots carrying 24-bit data plus 8 trailing 1s -> o_sample exactly 0x800001 when 0x800001 is sent; trailing bits ignored.
REQ-031 i_ready=0 for two consecutive words (0x000001 then 0x000002) -> o_overflow pulses once, o_sample=0x000002; raising i_ready yields one transfer.
REQ-032 lrclk toggles after 10 bits of a slot -> no o_valid for that slot; the next full slot is received correctly.
REQ-033 rst asserted for 1 cycle mid-slot, then a normal stream -> outputs at reset values; the first word appears only from the first complete slot after an lrclk edge.
REQ-034 i_ready asserted on the same edge as the next word completes -> both words delivered, o_valid continuous, o_overflow=0.
